// File: rtl/pipe_pkg.sv
// Shared pipeline-register definitions: NOP encoding, field widths,
// load/store one-hot bit positions, branch class and ALU op encodings.
package pipe_pkg;

  localparam int unsigned INSTR_W   = 32;
  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned ALU_OP_W  = 6;
  localparam int unsigned LS_INFO_W = 8;
  localparam int unsigned BR_INFO_W = 4;
  localparam int unsigned CNT_W     = 32;

  // addi x0,x0,0
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [ALU_OP_W-1:0] ALU_OP_ADD = 6'd0;

  // One-hot load/store info bit positions
  localparam int unsigned LS_LB  = 7;
  localparam int unsigned LS_LH  = 6;
  localparam int unsigned LS_LW  = 5;
  localparam int unsigned LS_LBU = 4;
  localparam int unsigned LS_LHU = 3;
  localparam int unsigned LS_SB  = 2;
  localparam int unsigned LS_SH  = 1;
  localparam int unsigned LS_SW  = 0;

  typedef enum logic [BR_INFO_W-1:0] {
    BR_NONE = 4'd0,
    BR_BEQ  = 4'd1,
    BR_BNE  = 4'd2,
    BR_BLT  = 4'd3,
    BR_BGE  = 4'd4,
    BR_BLTU = 4'd5,
    BR_BGEU = 4'd6,
    BR_JAL  = 4'd7,
    BR_JALR = 4'd8
  } br_info_e;

endpackage

// File: rtl/pipe_dff.sv
// Generic pipeline-register field: reset value, bubble image, stall hold.
// Priority: reset > bubble > stall > load.
module pipe_dff #(
  parameter int unsigned   W       = 1,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         stall,
  input  logic         bubble,
  input  logic [W-1:0] bubble_val,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Field register with bubble taking precedence over stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RST_VAL;
    end else if (bubble) begin
      q <= bubble_val;
    end else if (!stall) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_reg_execute.sv
// Decode-to-execute pipeline register (regE).
// Optional hazard-event counters are compiled in with PIPE_REG_PERF_CNT_EN.
module pipe_reg_execute #(
  parameter int unsigned XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = pipe_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ctrl_i_regE_stall,
  input  logic            ctrl_i_regE_bubble,
  input  logic            decode_i_valid,
  input  logic [XLEN-1:0] decode_i_pc,
  input  logic [31:0]     decode_i_instr,
  input  logic [4:0]      decode_i_rs1,
  input  logic [4:0]      decode_i_rs2,
  input  logic [4:0]      decode_i_rd,
  input  logic [XLEN-1:0] decode_i_rs1_data,
  input  logic [XLEN-1:0] decode_i_rs2_data,
  input  logic [XLEN-1:0] decode_i_imm,
  input  logic [5:0]      decode_i_alu_op,
  input  logic [7:0]      decode_i_load_store_info,
  input  logic [3:0]      decode_i_branch_info,
  input  logic            decode_i_pred_taken,
  output logic            regE_o_valid,
  output logic [XLEN-1:0] regE_o_pc,
  output logic [31:0]     regE_o_instr,
  output logic [4:0]      regE_o_rs1,
  output logic [4:0]      regE_o_rs2,
  output logic [4:0]      regE_o_rd,
  output logic [XLEN-1:0] regE_o_rs1_data,
  output logic [XLEN-1:0] regE_o_rs2_data,
  output logic [XLEN-1:0] regE_o_imm,
  output logic [5:0]      regE_o_alu_op,
  output logic [7:0]      regE_o_load_store_info,
  output logic [3:0]      regE_o_branch_info,
`ifdef PIPE_REG_PERF_CNT_EN
  output logic [31:0]     regE_o_bubble_cnt,
  output logic [31:0]     regE_o_stall_cnt,
`endif
  output logic            regE_o_pred_taken
);

  import pipe_pkg::*;

  logic [REG_IDX_W-1:0] rd_d;
  logic [LS_INFO_W-1:0] ls_d;
  logic [BR_INFO_W-1:0] br_d;
  logic                 pt_d;

  // Invalid slots must not raise load-use hazards or branch fixes downstream
  always_comb begin
    rd_d = '0;
    ls_d = '0;
    br_d = BR_NONE;
    pt_d = 1'b0;
    if (decode_i_valid) begin
      rd_d = decode_i_rd;
      ls_d = decode_i_load_store_info;
      br_d = decode_i_branch_info;
      pt_d = decode_i_pred_taken;
    end
  end

  pipe_dff #(.W(1), .RST_VAL(1'b0)) u_valid (
    .clk(clk), .rst_n(rst_n), .stall(ctrl_i_regE_stall), .bubble(ctrl_i_regE_bubble),
    .bubble_val(1'b0), .d(decode_i_valid), .q(regE_o_valid));

  pipe_dff #(.W(XLEN), .RST_VAL('0)) u_pc (
    .clk(clk), .rst_n(rst_n), .stall(ctrl_i_regE_stall), .bubble(ctrl_i_regE_bubble),
    .bubble_val('0), .d(decode_i_pc), .q(regE_o_pc));

  pipe_dff #(.W(INSTR_W), .RST_VAL(NOP_INSTR)) u_instr (
    .clk(clk), .rst_n(rst_n), .stall(ctrl_i_regE_stall), .bubble(ctrl_i_regE_bubble),
    .bubble_val(NOP_INSTR), .d(decode_i_instr), .q(regE_o_instr));

  pipe_dff #(.W(REG_IDX_W), .RST_VAL('0)) u_rs1 (
    .clk(clk), .rst_n(rst_n), .stall(ctrl_i_regE_stall), .bubble(ctrl_i_regE_bubble),
    .bubble_val('0), .d(decode_i_rs1), .q(regE_o_rs1));

  pipe_dff #(.W(REG_IDX_W), .RST_VAL('0)) u_rs2 (
    .clk(clk), .rst_n(rst_n), .stall(ctrl_i_regE_stall), .bubble(ctrl_i_regE_bubble),
    .bubble_val('0), .d(decode_i_rs2), .q(regE_o_rs2));

  pipe_dff #(.W(REG_IDX_W), .RST_VAL('0)) u_rd (
    .clk(clk), .rst_n(rst_n), .stall(ctrl_i_regE_stall), .bubble(ctrl_i_regE_bubble),
    .bubble_val('0), .d(rd_d), .q(regE_o_rd));

  pipe_dff #(.W(XLEN), .RST_VAL('0)) u_rs1_data (
    .clk(clk), .rst_n(rst_n), .stall(ctrl_i_regE_stall), .bubble(ctrl_i_regE_bubble),
    .bubble_val('0), .d(decode_i_rs1_data), .q(regE_o_rs1_data));

  pipe_dff #(.W(XLEN), .RST_VAL('0)) u_rs2_data (
    .clk(clk), .rst_n(rst_n), .stall(ctrl_i_regE_stall), .bubble(ctrl_i_regE_bubble),
    .bubble_val('0), .d(decode_i_rs2_data), .q(regE_o_rs2_data));

  pipe_dff #(.W(XLEN), .RST_VAL('0)) u_imm (
    .clk(clk), .rst_n(rst_n), .stall(ctrl_i_regE_stall), .bubble(ctrl_i_regE_bubble),
    .bubble_val('0), .d(decode_i_imm), .q(regE_o_imm));

  pipe_dff #(.W(ALU_OP_W), .RST_VAL(ALU_OP_ADD)) u_alu_op (
    .clk(clk), .rst_n(rst_n), .stall(ctrl_i_regE_stall), .bubble(ctrl_i_regE_bubble),
    .bubble_val(ALU_OP_ADD), .d(decode_i_alu_op), .q(regE_o_alu_op));

  pipe_dff #(.W(LS_INFO_W), .RST_VAL('0)) u_ls_info (
    .clk(clk), .rst_n(rst_n), .stall(ctrl_i_regE_stall), .bubble(ctrl_i_regE_bubble),
    .bubble_val('0), .d(ls_d), .q(regE_o_load_store_info));

  pipe_dff #(.W(BR_INFO_W), .RST_VAL(BR_NONE)) u_br_info (
    .clk(clk), .rst_n(rst_n), .stall(ctrl_i_regE_stall), .bubble(ctrl_i_regE_bubble),
    .bubble_val(BR_NONE), .d(br_d), .q(regE_o_branch_info));

  pipe_dff #(.W(1), .RST_VAL(1'b0)) u_pred_taken (
    .clk(clk), .rst_n(rst_n), .stall(ctrl_i_regE_stall), .bubble(ctrl_i_regE_bubble),
    .bubble_val(1'b0), .d(pt_d), .q(regE_o_pred_taken));

`ifdef PIPE_REG_PERF_CNT_EN
  logic [CNT_W-1:0] bubble_cnt_q;
  logic [CNT_W-1:0] stall_cnt_q;

  // Saturating hazard-event counters; a stall masked by a bubble is not counted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      if (ctrl_i_regE_bubble && (bubble_cnt_q != '1)) begin
        bubble_cnt_q <= bubble_cnt_q + 1'b1;
      end
      if (ctrl_i_regE_stall && !ctrl_i_regE_bubble && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
    end
  end

  assign regE_o_bubble_cnt = bubble_cnt_q;
  assign regE_o_stall_cnt  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_reg_execute.sv
// Scoreboard bench for pipe_reg_execute: driver pushes reference-model
// expectations, monitor pops and compares one cycle after each edge.
module tb_pipe_reg_execute;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam longint CNT_MAX = 64'h0000_0000_FFFF_FFFF;

  typedef struct {
    logic        rst_n, bubble, stall, valid;
    logic [31:0] pc, instr, rs1_data, rs2_data, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [5:0]  alu_op;
    logic [7:0]  ls;
    logic [3:0]  br;
    logic        pt;
  } in_t;

  typedef struct {
    logic        valid;
    logic [31:0] pc, instr, rs1_data, rs2_data, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [5:0]  alu_op;
    logic [7:0]  ls;
    logic [3:0]  br;
    logic        pt;
    longint      bcnt, scnt;
  } st_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic stall = 1'b0, bubble = 1'b0, valid = 1'b0, pt = 1'b0;
  logic [31:0] pc = '0, instr = '0, rs1_data = '0, rs2_data = '0, imm = '0;
  logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
  logic [5:0]  alu_op = '0;
  logic [7:0]  ls = '0;
  logic [3:0]  br = '0;

  logic        o_valid, o_pt;
  logic [31:0] o_pc, o_instr, o_rs1_data, o_rs2_data, o_imm;
  logic [4:0]  o_rs1, o_rs2, o_rd;
  logic [5:0]  o_alu_op;
  logic [7:0]  o_ls;
  logic [3:0]  o_br;
`ifdef PIPE_REG_PERF_CNT_EN
  logic [31:0] o_bcnt, o_scnt;
`endif

  int total = 0;
  int bad = 0;
  st_t model;
  st_t exp_q[$];

  always #5 clk = ~clk;

  pipe_reg_execute #(.XLEN(32), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n),
    .ctrl_i_regE_stall(stall), .ctrl_i_regE_bubble(bubble),
    .decode_i_valid(valid), .decode_i_pc(pc), .decode_i_instr(instr),
    .decode_i_rs1(rs1), .decode_i_rs2(rs2), .decode_i_rd(rd),
    .decode_i_rs1_data(rs1_data), .decode_i_rs2_data(rs2_data), .decode_i_imm(imm),
    .decode_i_alu_op(alu_op), .decode_i_load_store_info(ls),
    .decode_i_branch_info(br), .decode_i_pred_taken(pt),
    .regE_o_valid(o_valid), .regE_o_pc(o_pc), .regE_o_instr(o_instr),
    .regE_o_rs1(o_rs1), .regE_o_rs2(o_rs2), .regE_o_rd(o_rd),
    .regE_o_rs1_data(o_rs1_data), .regE_o_rs2_data(o_rs2_data), .regE_o_imm(o_imm),
    .regE_o_alu_op(o_alu_op), .regE_o_load_store_info(o_ls),
    .regE_o_branch_info(o_br),
`ifdef PIPE_REG_PERF_CNT_EN
    .regE_o_bubble_cnt(o_bcnt), .regE_o_stall_cnt(o_scnt),
`endif
    .regE_o_pred_taken(o_pt));

  function automatic st_t nop_image(longint b, longint s);
    st_t n;
    n.valid = 1'b0; n.pc = '0; n.instr = NOP; n.rs1_data = '0; n.rs2_data = '0;
    n.imm = '0; n.rs1 = '0; n.rs2 = '0; n.rd = '0; n.alu_op = '0; n.ls = '0;
    n.br = '0; n.pt = 1'b0; n.bcnt = b; n.scnt = s;
    return n;
  endfunction

  // Reference behaviour: what the register holds after the edge that sees `i`
  function automatic st_t ref_next(st_t s, in_t i);
    st_t n = s;
    if (!i.rst_n) return nop_image(0, 0);
    if (i.bubble) begin
      n = nop_image(s.bcnt + 1 > CNT_MAX ? CNT_MAX : s.bcnt + 1, s.scnt);
    end else if (i.stall) begin
      n.scnt = s.scnt + 1 > CNT_MAX ? CNT_MAX : s.scnt + 1;
    end else begin
      n.valid = i.valid; n.pc = i.pc; n.instr = i.instr;
      n.rs1_data = i.rs1_data; n.rs2_data = i.rs2_data; n.imm = i.imm;
      n.rs1 = i.rs1; n.rs2 = i.rs2; n.alu_op = i.alu_op;
      n.rd = i.valid ? i.rd : 5'd0;
      n.ls = i.valid ? i.ls : 8'd0;
      n.br = i.valid ? i.br : 4'd0;
      n.pt = i.valid ? i.pt : 1'b0;
    end
    return n;
  endfunction

  function automatic in_t rnd_in();
    in_t i;
    i.rst_n = 1'b1; i.bubble = 1'b0; i.stall = 1'b0;
    i.valid = 1'($urandom); i.pc = $urandom; i.instr = $urandom;
    i.rs1_data = $urandom; i.rs2_data = $urandom; i.imm = $urandom;
    i.rs1 = 5'($urandom); i.rs2 = 5'($urandom); i.rd = 5'($urandom);
    i.alu_op = 6'($urandom); i.ls = 8'(1 << $urandom_range(0, 7));
    i.br = 4'($urandom_range(0, 8)); i.pt = 1'($urandom);
    return i;
  endfunction

  // Apply one cycle of stimulus at the falling edge and queue the expectation
  task automatic drive(input in_t i);
    @(negedge clk);
    rst_n = i.rst_n; bubble = i.bubble; stall = i.stall; valid = i.valid;
    pc = i.pc; instr = i.instr; rs1_data = i.rs1_data; rs2_data = i.rs2_data;
    imm = i.imm; rs1 = i.rs1; rs2 = i.rs2; rd = i.rd; alu_op = i.alu_op;
    ls = i.ls; br = i.br; pt = i.pt;
    model = ref_next(model, i);
    exp_q.push_back(model);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: the register presents a new value after every rising edge
  initial begin
    st_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("valid", 32'(o_valid), 32'(e.valid));
        check("pc", o_pc, e.pc);
        check("instr", o_instr, e.instr);
        check("rs1", 32'(o_rs1), 32'(e.rs1));
        check("rs2", 32'(o_rs2), 32'(e.rs2));
        check("rd", 32'(o_rd), 32'(e.rd));
        check("rs1_data", o_rs1_data, e.rs1_data);
        check("rs2_data", o_rs2_data, e.rs2_data);
        check("imm", o_imm, e.imm);
        check("alu_op", 32'(o_alu_op), 32'(e.alu_op));
        check("ls_info", 32'(o_ls), 32'(e.ls));
        check("br_info", 32'(o_br), 32'(e.br));
        check("pred_taken", 32'(o_pt), 32'(e.pt));
`ifdef PIPE_REG_PERF_CNT_EN
        check("bubble_cnt", o_bcnt, e.bcnt[31:0]);
        check("stall_cnt", o_scnt, e.scnt[31:0]);
`endif
      end
    end
  end

  initial begin
    in_t i;
    model = nop_image(0, 0);

    // Reset held for three edges with random decode inputs
    repeat (3) begin
      i = rnd_in(); i.rst_n = 1'b0; i.stall = 1'($urandom); i.bubble = 1'($urandom);
      drive(i);
    end

    // Normal flow
    i = rnd_in(); i.valid = 1'b1; i.pc = 32'h8000_0000; i.instr = 32'h00A0_0093; i.rd = 5'd1;
    drive(i);

    // lw into rd=5 followed by a load-use bubble
    i = rnd_in(); i.valid = 1'b1; i.ls = 8'h20; i.rd = 5'd5;
    drive(i);
    i = rnd_in(); i.bubble = 1'b1;
    drive(i);

    // Load pc=0x100 then stall four cycles while decode changes
    i = rnd_in(); i.valid = 1'b1; i.pc = 32'h0000_0100;
    drive(i);
    repeat (4) begin
      i = rnd_in(); i.stall = 1'b1;
      drive(i);
    end

    // Bubble and stall together
    i = rnd_in(); i.valid = 1'b1;
    drive(i);
    i = rnd_in(); i.bubble = 1'b1; i.stall = 1'b1;
    drive(i);

    // Invalid slot: hazard-relevant fields forced to zero
    i = rnd_in(); i.valid = 1'b0; i.rd = 5'd7; i.ls = 8'h20; i.br = 4'd3; i.pt = 1'b1;
    drive(i);

    // Back-to-back bubbles
    repeat (2) begin
      i = rnd_in(); i.bubble = 1'b1;
      drive(i);
    end

    // Randomised traffic including occasional mid-run resets
    repeat (300) begin
      i = rnd_in();
      i.bubble = ($urandom_range(0, 99) < 15);
      i.stall  = ($urandom_range(0, 99) < 25);
      i.rst_n  = ($urandom_range(0, 99) >= 3);
      drive(i);
    end

`ifdef PIPE_REG_PERF_CNT_EN
    // Saturation: preload the bubble counter at its maximum
    i = rnd_in(); i.valid = 1'b1;
    drive(i);
    @(negedge clk);
    force dut.bubble_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.bubble_cnt_q;
    model.bcnt = CNT_MAX;
    i = rnd_in(); i.bubble = 1'b1;
    drive(i);
    i = rnd_in(); i.bubble = 1'b1;
    drive(i);
`endif

    // Drain the scoreboard within a bounded number of cycles
    for (int n = 0; n < 10 && exp_q.size() > 0; n++) @(posedge clk);
    #2;
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_reg_execute.md
# pipe_reg_execute

Decode-to-execute pipeline register (regE): captures decoded instruction fields every cycle and presents them to the execute stage. It is the consumer side of the hazard controller's regE stall/bubble interface. It returns `regE_o_rd` and `regE_o_load_store_info` to the controller for load-use detection. It also carries a valid bit and optional hazard-event counters.

## Interface
- `XLEN`, 32: datapath width (pc, instr, operands, imm)
- `NOP_INSTR`, 32'h0000_0013: encoding loaded on bubble (addi x0,x0,0)
- `clk` input 1: clock, all state updates on rising edge
- `rst_n` input 1: reset, asynchronous, active-low
- `ctrl_i_regE_stall` input 1: hold current contents
- `ctrl_i_regE_bubble` input 1: load NOP/invalid next edge
- `decode_i_valid` input 1: decode holds a real instruction
- `decode_i_pc` input XLEN: instruction PC
- `decode_i_instr` input 32: raw instruction
- `decode_i_rs1`, `decode_i_rs2`, `decode_i_rd` input 5 each: register indices
- `decode_i_rs1_data`, `decode_i_rs2_data` input XLEN: operand values
- `decode_i_imm` input XLEN: immediate
- `decode_i_alu_op` input 6: ALU operation code
- `decode_i_load_store_info` input 8: one-hot {lb,lh,lw,lbu,lhu,sb,sh,sw}, bit 7 = lb
- `decode_i_branch_info` input 4: branch/jump class; 0 = none
- `decode_i_pred_taken` input 1: branch prediction from fetch
- `regE_o_*` output (same widths): registered copy of every `decode_i_*` field, including `regE_o_valid`
- `regE_o_bubble_cnt`, `regE_o_stall_cnt` output 32: event counters; present only with `PIPE_REG_PERF_CNT_EN`

## Operation
- Per-edge update, priority order:
  - reset
  - bubble
  - stall
  - load
- Bubble: next state is the NOP image:
  - valid=0, instr=NOP_INSTR, rd=rs1=rs2=0
  - load_store_info=0, branch_info=0, pred_taken=0
  - alu_op=0 (ADD), operands/imm=0, pc=0
- Stall without bubble: all fields hold, including valid.
- Load: all fields take `decode_i_*`. If `decode_i_valid`=0, the register still loads the fields, but rd, load_store_info, branch_info and pred_taken are forced to 0. Invalid slots therefore never create false load-use hazards or branch fixes.
- Bubble+stall asserted together: bubble wins. The stall is ignored for that edge and no stall is counted.
- The NOP image guarantees rd=0, so the controller's load-use compare is harmless against an inserted bubble.
- Counters (when compiled in):
  - bubble_cnt increments on each edge with bubble=1.
  - stall_cnt increments on each edge with stall=1 and bubble=0.
  - Both saturate at 32'hFFFF_FFFF and do not wrap.

## Timing
- Latency 1 cycle, decode input to `regE_o_*`.
- All outputs are registered. No combinational path from any input to any output.
- Reset value of every output is the NOP image. Counters reset to 0.
- `rst_n` asserted mid-operation clears state immediately (asynchronous), overriding stall/bubble. The first load occurs on the first rising edge after deassertion.
- Stall/bubble are sampled on the same edge as the data. Back-to-back bubbles keep the NOP image. Each bubble edge counts once.

## Configuration
- `PIPE_REG_PERF_CNT_EN`:
  - Defined: the two 32-bit saturating counters and their output ports exist.
  - Undefined: the ports and logic are absent, and pipeline-field behaviour is identical.

## Structure
- Shared package `pipe_pkg` holds:
  - NOP_INSTR
  - load_store_info bit indices (LS_LB=7 … LS_SW=0)
  - branch_info encodings
  - ALU_OP_ADD
  - the field-width constants
- One natural sub-module, `pipe_dff`: a parameterised width/reset-value flop with stall/bubble inputs and a bubble-value port. It is instantiated once per field and reused by the F/D/M/W pipeline registers.

## Test plan
- Reset: rst_n=0 for 3 cycles with random decode inputs. All outputs must show the NOP image (instr=0x00000013, valid=0, rd=0, load_store_info=0), and counters must be 0.
- Normal flow: pc=0x80000000, instr=0x00A00093, rd=1, valid=1, no stall/bubble. The next cycle must show regE_o_pc=0x80000000, regE_o_rd=1, regE_o_valid=1.
- Load-use bubble: regE holds lw (load_store_info=0x20, rd=5), then assert bubble for 1 cycle. The next cycle must show valid=0 and rd=0, and bubble_cnt must equal 1.
- Stall hold: load pc=0x100, then stall for 4 cycles while decode inputs change. Outputs must stay at pc=0x100, and stall_cnt must equal 4.
- Simultaneous bubble+stall for 1 cycle: the NOP image must load, bubble_cnt must increase by 1, and stall_cnt must be unchanged.
- Invalid load plus saturation:
  - With decode_i_valid=0, rd=7, load_store_info=0x20, the outputs must show rd=0 and load_store_info=0.
  - With bubble_cnt forced to 0xFFFFFFFF, a further bubble must leave it at 0xFFFFFFFF.
